// File: rtl/vjtag_master_if.sv
// vjtag_master_if: command/response handshake between a host and vjtag_master
//   cmd_valid/cmd_ready  command handshake, accepted when both high at posedge
//   cmd_op/addr/wdata    operation code, memory address and write data
//   rsp_valid            one-cycle response pulse, no backpressure
//   rsp_data/rsp_err     captured data-register bits and illegal-op flag
interface vjtag_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/vjtag_master.sv
// vjtag_master: sequences virtual-JTAG IR/DR strobes to run one command per request
//   tck, aclr         clock and synchronous active-low reset
//   bus (slave)       command in / response out handshake
//   ir_in             virtual IR code: 00 BYPASS, 01 DIP, 10 LED, 11 MEM
//   v_uir/v_cdr/v_sdr/v_udr  update-IR, capture-DR, shift-DR, update-DR strobes
//   tdi, tdo          serial data to / from the target, LSB first
module vjtag_master (
  input  logic           tck,
  input  logic           aclr,
  vjtag_master_if.slave  bus,
  output logic [1:0]     ir_in,
  output logic           v_uir,
  output logic           v_cdr,
  output logic           v_sdr,
  output logic           v_udr,
  output logic           tdi,
  input  logic           tdo
);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;
  state_t      state, state_nxt;
  logic        pass;
  logic [4:0]  cnt;
  logic [4:0]  len;
  logic [2:0]  op;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [15:0] word;
  logic [15:0] cap, cap_nxt;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        in_rst;
  logic        accept;
  logic        legal;
  logic        last_bit;
  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign legal    = bus.cmd_op <= 3'd4;
  assign len      = op == 3'd0 ? 5'd2 : (op == 3'd1 || op == 3'd2) ? 5'd8 : 5'd16;
  assign last_bit = cnt == len - 5'd1;
  assign word     = op == 3'd2 ? {8'h00, wdata} :
                    op == 3'd3 ? {addr, wdata} :
                    op == 3'd4 ? {addr, 8'h00} : 16'h0000;
  always_ff @(posedge tck)
    state <= !aclr ? IDLE : state_nxt;
  // MEM_RD makes two passes: the first loads the address, the second
  // re-shifts it while capturing the memory data; it never issues update-DR.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (legal ? UIR : RESP) : IDLE;
      UIR:     state_nxt = CDR;
      CDR:     state_nxt = SDR;
      SDR:     state_nxt = !last_bit ? SDR : op != 3'd4 ? UDR : pass ? RESP : CDR;
      UDR:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Capture is cleared at CDR so shorter registers come out zero-extended.
  always_comb begin
    cap_nxt = cap;
    if (state == SDR) cap_nxt[cnt[3:0]] = tdo;
  end
  always_ff @(posedge tck) begin
    if (!aclr) begin
      in_rst   <= 1'b1;
      pass     <= 1'b0;
      cnt      <= 5'd0;
      op       <= 3'd0;
      addr     <= 8'h00;
      wdata    <= 8'h00;
      cap      <= 16'h0000;
      rsp_data <= 16'h0000;
      rsp_err  <= 1'b0;
    end else begin
      in_rst <= 1'b0;
      if (accept) begin
        op    <= bus.cmd_op;
        addr  <= bus.cmd_addr;
        wdata <= bus.cmd_wdata;
      end
      cnt  <= (state == SDR && !last_bit) ? cnt + 5'd1 : 5'd0;
      pass <= state == IDLE ? 1'b0 : (state == SDR && last_bit) ? 1'b1 : pass;
      cap  <= state == CDR ? 16'h0000 : cap_nxt;
      // The response is built on the edge entering RESP so the final tdo bit
      // is included and the value holds until the next response.
      if (state_nxt == RESP) begin
        rsp_data <= state == IDLE ? 16'h0000 : cap_nxt;
        rsp_err  <= state == IDLE;
      end
    end
  end
  // in_rst keeps cmd_ready low for the cycles spent in reset.
  always_comb begin
    bus.cmd_ready = state == IDLE && !in_rst;
    bus.rsp_valid = state == RESP;
    bus.rsp_data  = rsp_data;
    bus.rsp_err   = rsp_err;
    v_uir         = state == UIR;
    v_cdr         = state == CDR;
    v_sdr         = state == SDR;
    v_udr         = state == UDR;
    ir_in         = (state == IDLE || state == RESP) ? 2'b00 : (op[2] ? 2'b11 : op[1:0]);
    tdi           = state == SDR && word[cnt[3:0]];
  end
endmodule
